qbert_only_led_pio: RTL and testbench

Avalon-MM slave output port that drives a WIDTH-bit output bus (board LEDs/strobes) from Nios II writes.
- It is the transmit-side counterpart of the read-only switch input port and sits on the same system interconnect.
- Beyond a plain data register it provides atomic bit set/clear, a one-shot timed pulse overlay, and a free-running blink overlay, so software need not bit-bang timing.
- Reads return register contents with one-cycle latency.

---
 rtl/qbert_only_led_pio.sv | 125 ++++++++++++
 tb/tb_qbert_only_led_pio.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/qbert_only_led_pio.sv
// Avalon-MM LED/strobe output port: data register with atomic set/clear,
// a one-shot timed pulse overlay and a free-running blink overlay.
module qbert_only_led_pio #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               BLINK_DIV   = 25000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TERM = PW'(BLINK_DIV - 1);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_PLEN     = 3'd1;
  localparam logic [2:0] ADDR_PTRIG    = 3'd2;
  localparam logic [2:0] ADDR_BLINK    = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
  localparam logic [2:0] ADDR_PCNT     = 3'd6;
  localparam logic [2:0] ADDR_PHASE    = 3'd7;

  logic [WIDTH-1:0] data_q, data_d;
  logic [15:0]      plen_q, plen_d;
  logic [WIDTH-1:0] pmask_q, pmask_d;
  logic [15:0]      pcnt_q, pcnt_d;
  logic [WIDTH-1:0] blink_q, blink_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             phase_q, phase_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             wrEn;
  logic [WIDTH-1:0] wd;
  logic             pulseActive;
  logic             unusedWd;

  assign wrEn        = chipselect & ~write_n;
  assign wd          = writedata[WIDTH-1:0];
  assign pulseActive = (pcnt_q != 16'd0);
  assign unusedWd    = &{1'b0, writedata};

  always_comb begin
    data_d  = data_q;
    plen_d  = plen_q;
    blink_d = blink_q;
    if (wrEn) begin
      case (address)
        ADDR_DATA:     data_d  = wd;
        ADDR_PLEN:     plen_d  = writedata[15:0];
        ADDR_BLINK:    blink_d = wd;
        ADDR_OUTSET:   data_d  = data_q | wd;
        ADDR_OUTCLEAR: data_d  = data_q & ~wd;
        default:       ;
      endcase
    end
  end

  // A trigger wins over the countdown, so a retrigger on the final cycle reloads.
  always_comb begin
    pcnt_d  = pcnt_q;
    pmask_d = pmask_q;
    if (wrEn && (address == ADDR_PTRIG) && (plen_q != 16'd0)) begin
      pcnt_d  = plen_q;
      pmask_d = (pulseActive ? pmask_q : '0) | wd;
    end else if (pulseActive) begin
      pcnt_d = pcnt_q - 16'd1;
      if (pcnt_q == 16'd1) pmask_d = '0;
    end
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    phase_d = phase_q;
    if (presc_q == PRESC_TERM) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:  readdata_d[WIDTH-1:0] = data_q;
      ADDR_PLEN:  readdata_d[15:0]      = plen_q;
      ADDR_PTRIG: readdata_d[WIDTH-1:0] = pulseActive ? pmask_q : '0;
      ADDR_BLINK: readdata_d[WIDTH-1:0] = blink_q;
      ADDR_PCNT:  readdata_d[15:0]      = pcnt_q;
      ADDR_PHASE: readdata_d[0]         = phase_q;
      default:    readdata_d            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      plen_q     <= '0;
      pmask_q    <= '0;
      pcnt_q     <= '0;
      blink_q    <= '0;
      presc_q    <= '0;
      phase_q    <= 1'b0;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      plen_q     <= plen_d;
      pmask_q    <= pmask_d;
      pcnt_q     <= pcnt_d;
      blink_q    <= blink_d;
      presc_q    <= presc_d;
      phase_q    <= phase_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = (data_q | (pulseActive ? pmask_q : '0)) ^ (blink_q & {WIDTH{phase_q}});

endmodule

// File: tb/tb_qbert_only_led_pio.sv
// Directed testbench for qbert_only_led_pio (WIDTH=4, RESET_VALUE=5, BLINK_DIV=3).
module tb_qbert_only_led_pio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  out_port;

  int checkCount = 0;
  int passCount  = 0;

  qbert_only_led_pio #(.WIDTH(4), .RESET_VALUE(4'h5), .BLINK_DIV(3)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  // All stimulus and sampling happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic readReg(input logic [2:0] a, output logic [31:0] v);
    address = a;
    tick();
    v = readdata;
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    else passCount++;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    check32("reset out_port", {28'd0, out_port}, 32'h5);
    check32("reset readdata", readdata, 32'h0);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_data();
    logic [31:0] v;
    writeReg(3'd0, 32'hA);
    check32("data write out", {28'd0, out_port}, 32'hA);
    readReg(3'd0, v);
    check32("data readback", v, 32'hA);
    writeReg(3'd0, 32'hFFFF_FFF0);
    readReg(3'd0, v);
    check32("data upper bits ignored", v, 32'h0);
    writeReg(3'd0, 32'h3);
    writeReg(3'd4, 32'h8);
    check32("outset", {28'd0, out_port}, 32'hB);
    writeReg(3'd5, 32'h1);
    check32("outclear", {28'd0, out_port}, 32'hA);
    readReg(3'd4, v);
    check32("outset reads 0", v, 32'h0);
    writeReg(3'd6, 32'h1234);
    readReg(3'd6, v);
    check32("pcnt write ignored", v, 32'h0);
  endtask

  task automatic test_pulse();
    logic [31:0] v;
    writeReg(3'd1, 32'd5);
    writeReg(3'd0, 32'h0);
    writeReg(3'd2, 32'h1);
    address = 3'd6;
    for (int j = 1; j <= 6; j++) begin
      check32($sformatf("pulse out cycle %0d", j), {28'd0, out_port}, (j <= 5) ? 32'h1 : 32'h0);
      tick();
      check32($sformatf("pcnt read %0d", j), readdata, 32'(6 - j));
    end
    readReg(3'd2, v);
    check32("ptrig read after pulse", v, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    writeReg(3'd1, 32'd4);
    writeReg(3'd2, 32'h1);
    check32("retrig first s1", {28'd0, out_port}, 32'h1);
    tick();
    check32("retrig first s2", {28'd0, out_port}, 32'h1);
    tick();
    check32("retrig first s3", {28'd0, out_port}, 32'h1);
    writeReg(3'd2, 32'h2);
    for (int j = 4; j <= 7; j++) begin
      check32($sformatf("retrig ext s%0d", j), {28'd0, out_port}, 32'h3);
      tick();
    end
    check32("retrig end", {28'd0, out_port}, 32'h0);
    writeReg(3'd1, 32'd0);
    writeReg(3'd2, 32'hF);
    check32("plen0 no pulse", {28'd0, out_port}, 32'h0);
    readReg(3'd6, v);
    check32("plen0 pcnt", v, 32'h0);
  endtask

  function automatic logic expPhase(input int pos);
    return ((pos / 3) % 2) == 0;
  endfunction

  task automatic test_blink();
    writeReg(3'd0, 32'h4);
    writeReg(3'd3, 32'h4);
    address = 3'd7;
    for (int i = 0; i < 10 && out_port !== 4'h4; i++) tick();
    check32("blink wait phase0", {28'd0, out_port}, 32'h4);
    for (int i = 0; i < 10 && out_port !== 4'h0; i++) tick();
    check32("blink wait phase1", {28'd0, out_port}, 32'h0);
    for (int pos = 1; pos <= 5; pos++) begin
      tick();
      check32($sformatf("blink out pos%0d", pos), {28'd0, out_port}, expPhase(pos) ? 32'h0 : 32'h4);
      check32($sformatf("phase read pos%0d", pos), {31'd0, readdata[0]}, {31'd0, expPhase(pos - 1)});
    end
    writeReg(3'd3, 32'h4);
    for (int pos = 6; pos <= 11; pos++) begin
      check32($sformatf("blink after rewrite pos%0d", pos), {28'd0, out_port}, expPhase(pos) ? 32'h0 : 32'h4);
      tick();
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] v;
    writeReg(3'd1, 32'd7);
    writeReg(3'd2, 32'h1);
    readReg(3'd6, v);
    check32("pcnt before reset", v, 32'd7);
    tick();
    reset_n = 1'b0;
    #1;
    check32("async reset out", {28'd0, out_port}, 32'h5);
    repeat (2) @(posedge clk);
    #1;
    check32("held reset out", {28'd0, out_port}, 32'h5);
    reset_n = 1'b1;
    readReg(3'd6, v);
    check32("post reset pcnt", v, 32'h0);
    readReg(3'd7, v);
    check32("post reset phase", v, 32'h0);
    readReg(3'd2, v);
    check32("post reset ptrig", v, 32'h0);
    readReg(3'd3, v);
    check32("post reset blink", v, 32'h0);
    check32("post reset out", {28'd0, out_port}, 32'h5);
  endtask

  initial begin
    test_reset();
    test_data();
    test_pulse();
    test_back_to_back();
    test_blink();
    test_reset_midop();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
